serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder that accepts two parallel operands plus carry-in and produces their sum one bit per clock, LSB first. It reuses the 1-bit full-adder cell (A, B, Cin -> Sum, Cout) as its datapath, with a carry flip-flop and operand/result shift registers around it. It sits directly upstream of result consumers that need a registered multi-bit sum with a valid strobe, and trades latency for area against a parallel ripple adder.

## Interface
- WIDTH, 8, operand and sum width in bits (>= 2)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- Start  input  1  request strobe; sampled only when not Busy
- A  input  WIDTH  operand A; sampled on Start acceptance only
- B  input  WIDTH  operand B; sampled on Start acceptance only
- Cin  input  1  carry-in; sampled on Start acceptance only
- Busy  output  1  high while a serial addition is in progress
- Done  output  1  single-cycle pulse: Sum/Cout (and Ovf) just updated
- Sum  output  WIDTH  registered result, held until next completion
- Cout  output  1  registered carry out of bit WIDTH-1
- Ovf  output  1  signed overflow flag (present only with SERIAL_ADDER_OVF_EN)

## Operation
- States: IDLE, ADD, DONE. Reset -> IDLE.
- IDLE/DONE + Start=1: load opA<=A, opB<=B, carry<=Cin, bit counter<=0, partial result<=0; go ADD. Start=0: IDLE/DONE -> IDLE.
- ADD, each cycle: full-add opA[0], opB[0], carry; shift the sum bit into partial result MSB end (result shifts right); opA, opB shift right; carry <= full-adder Cout; counter++.
- ADD after processing bit WIDTH-1: copy partial result to Sum, carry to Cout; go DONE.
- DONE: Done=1 for exactly this cycle; Busy=0.
- Start while in ADD: ignored, no queuing. A/B/Cin changes after acceptance: ignored.
- Sum/Cout/Ovf change only on entering DONE; they hold the previous result throughout ADD.
- Arithmetic: {Cout,Sum} = A + B + Cin, unsigned, exact over WIDTH+1 bits.
- Counter width clog2(WIDTH); wrap not reachable (exits at WIDTH-1).

## Timing
- Reset (rst=1 at a rising edge): Busy=0, Done=0, Sum=0, Cout=0, Ovf=0, state IDLE, internal registers cleared. Takes precedence over Start.
- Start accepted at edge E0: Busy=1 from after E0 through after edge E0+WIDTH-1 (WIDTH cycles).
- Edge E0+WIDTH: Sum/Cout valid, Done=1, Busy=0 for one cycle.
- Latency Start-accept to Done: WIDTH+1 edges inclusive of E0 (WIDTH edges after E0).
- Back-to-back: Start=1 during the DONE cycle is accepted at edge E0+WIDTH+1; throughput one result per WIDTH+1 cycles.
- Reset mid-ADD: operation aborted, no Done pulse, outputs return to reset values at that edge.

## Configuration
- SERIAL_ADDER_OVF_EN defined: Ovf port and logic present; on DONE entry Ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), i.e. two's-complement overflow of A+B+Cin. Carry into MSB captured in a dedicated flop during the final ADD cycle.
- Not defined: Ovf port and its flops absent; all other behaviour identical.

## Test plan
- Reset: hold rst=1 two cycles with Start=1 -> Busy=0, Done=0, Sum=8'h00, Cout=0 throughout; no operation starts.
- WIDTH=8, A=8'h3C, B=8'h0F, Cin=0, Start pulse at E0 -> Busy high 8 cycles, Done pulse after edge E0+8 with Sum=8'h4B, Cout=0; Sum stays 8'h4B afterwards.
- A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1; A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1, Ovf=0 (macro on).
- Macro on: A=8'h7F, B=8'h01, Cin=0 -> Sum=8'h80, Cout=0, Ovf=1; A=8'h80, B=8'h80 -> Sum=8'h00, Cout=1, Ovf=1.
- Start with A=8'h01,B=8'h02; at cycle 3 pulse Start again and change A/B to 8'hAA/8'h55 -> second Start ignored, Done once with Sum=8'h03; Start in DONE cycle then accepted, next Done after 8 more edges.
- Start A=8'h10,B=8'h20; assert rst at 4th ADD cycle -> Busy=0, Sum=0, no Done; new Start A=8'h05,B=8'h06 -> Sum=8'h0B, Cout=0.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle for the bit-serial adder.
//   master : drives Start, A, B, Cin; observes Busy, Done, Sum, Cout (and Ovf)
//   slave  : the adder side of the same signals
// Ovf is present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             Ovf;
`endif

    modport master (
        output Start, A, B, Cin,
`ifdef SERIAL_ADDER_OVF_EN
        input  Ovf,
`endif
        input  Busy, Done, Sum, Cout
    );

    modport slave (
        input  Start, A, B, Cin,
`ifdef SERIAL_ADDER_OVF_EN
        output Ovf,
`endif
        output Busy, Done, Sum, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one sum bit per clock, LSB first.
// A single full-adder cell plus a carry flop and operand/result shift registers.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - serial_adder_if.slave: Start/A/B/Cin in, Busy/Done/Sum/Cout(/Ovf) out
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow flag Ovf.
// Latency: Start accepted at edge E0 -> Done pulse after edge E0+WIDTH.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_sum_bit;
    logic             w_carry_out;
    logic [WIDTH-1:0] w_part_next;

    // Full-adder cell on the current LSBs.
    assign w_sum_bit   = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_carry_out = (r_op_a[0] & r_op_b[0]) | (r_carry & (r_op_a[0] ^ r_op_b[0]));

    // New sum bit enters at the MSB end; after WIDTH shifts bit 0 lands at index 0.
    assign w_part_next = {w_sum_bit, r_part[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_part  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (bus.Start) begin
                        r_op_a  <= bus.A;
                        r_op_b  <= bus.B;
                        r_carry <= bus.Cin;
                        r_cnt   <= '0;
                        r_part  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StAdd;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StAdd: begin
                    r_part  <= w_part_next;
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_carry <= w_carry_out;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_sum   <= w_part_next;
                        r_cout  <= w_carry_out;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry here is the carry into the MSB.
                        r_ovf   <= r_carry ^ w_carry_out;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.Busy = r_busy;
    assign bus.Done = r_done;
    assign bus.Sum  = r_sum;
    assign bus.Cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.Ovf  = r_ovf;
`endif

endmodule
